// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU execute-stage types and constants
// Used by the iterative divider (iter_div) and the iterative multiplier control.
//   div_state_t : IDLE / BUSY / DONE sequencing for iterative units
//   DIV_WIDTH   : default operand/result width of the divider
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH = 32;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational radix-2 restoring division step
// Ports:
//   rem_i     [WIDTH]  partial remainder entering the step (always < divisor_i)
//   dvd_bit_i [1]      next dividend bit shifted into the remainder
//   divisor_i [WIDTH]  divisor magnitude
//   rem_o     [WIDTH]  partial remainder after the step
//   q_bit_o   [1]      quotient bit (1 when the trial subtract does not borrow)
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dvd_bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    // WIDTH+1 bits: the shifted remainder can exceed the WIDTH range.
    logic [WIDTH:0] shifted;

    assign shifted = {rem_i, dvd_bit_i};

    // Trial subtract succeeds when it would not borrow.
    assign q_bit_o = (shifted >= {1'b0, divisor_i});

    // On success the true difference is below the divisor, so the low
    // WIDTH bits of a wrapping subtract are exact.
    assign rem_o = q_bit_o ? (shifted[WIDTH-1:0] - divisor_i) : shifted[WIDTH-1:0];

endmodule

// File: rtl/iter_div.sv
// rtl/iter_div.sv - iterative radix-2 restoring signed/unsigned integer divider
// Optional feature macro: DIV_EARLY_OUT_EN (zero divisor goes straight to DONE).
// Ports:
//   clk, reset             clock; synchronous active-high reset
//   in_valid / in_ready    operand handshake (in_ready only while IDLE)
//   src1, src2, is_signed  dividend, divisor, signed-mode select
//   out_valid / out_ready  result handshake (out_valid held in DONE until consumed)
//   quotient, remainder    results (quotient truncates toward zero, remainder follows dividend sign)
//   div_by_zero            divisor was zero, valid with out_valid
module iter_div
    import alu_pkg::*;
#(
    parameter  int WIDTH = DIV_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q;       // partial remainder
    logic [WIDTH-1:0] dvd_q;       // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] dvs_q;       // divisor magnitude
    logic [WIDTH-1:0] src1_q;      // original dividend for the divide-by-zero remainder
    logic             q_neg_q;
    logic             r_neg_q;
    logic             dbz_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rmd_q;
    logic             dbz_out_q;

    logic             s1_neg;
    logic             s2_neg;
    logic [WIDTH-1:0] abs1;
    logic [WIDTH-1:0] abs2;
    logic             src2_zero;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] q_raw;
    logic [WIDTH-1:0] quot_d;
    logic [WIDTH-1:0] rmd_d;

    assign s1_neg    = is_signed & src1[WIDTH-1];
    assign s2_neg    = is_signed & src2[WIDTH-1];
    // -2^(WIDTH-1) negates to itself, which is also its correct unsigned magnitude.
    assign abs1      = s1_neg ? (~src1 + 1'b1) : src1;
    assign abs2      = s2_neg ? (~src2 + 1'b1) : src2;
    assign src2_zero = (src2 == '0);

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_i    (rem_q),
        .dvd_bit_i(dvd_q[WIDTH-1]),
        .divisor_i(dvs_q),
        .rem_o    (step_rem),
        .q_bit_o  (step_q)
    );

    assign q_raw = {dvd_q[WIDTH-2:0], step_q};

    // Sign fix-up on the final step's result; divide-by-zero overrides it.
    always_comb begin
        quot_d = q_neg_q ? (~q_raw + 1'b1) : q_raw;
        rmd_d  = r_neg_q ? (~step_rem + 1'b1) : step_rem;
        if (dbz_q) begin
            quot_d = '1;
            rmd_d  = src1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            src1_q      <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            dbz_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quot_q      <= '0;
            rmd_q       <= '0;
            dbz_out_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        rem_q      <= '0;
                        dvd_q      <= abs1;
                        dvs_q      <= abs2;
                        src1_q     <= src1;
                        q_neg_q    <= s1_neg ^ s2_neg;
                        r_neg_q    <= s1_neg;
                        dbz_q      <= src2_zero;
                        in_ready_q <= 1'b0;
`ifdef DIV_EARLY_OUT_EN
                        if (src2_zero) begin
                            state_q     <= DONE;
                            cnt_q       <= '0;
                            out_valid_q <= 1'b1;
                            quot_q      <= '1;
                            rmd_q       <= src1;
                            dbz_out_q   <= 1'b1;
                        end else begin
                            state_q <= BUSY;
                            cnt_q   <= CNT_W'(WIDTH);
                        end
`else
                        state_q <= BUSY;
                        cnt_q   <= CNT_W'(WIDTH);
`endif
                    end
                end
                BUSY: begin
                    rem_q <= step_rem;
                    dvd_q <= q_raw;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        quot_q      <= quot_d;
                        rmd_q       <= rmd_d;
                        dbz_out_q   <= dbz_q;
                    end
                end
                DONE: begin
                    // Results hold until consumed; in_ready returns one cycle later.
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quot_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_out_q;

endmodule
